branch_predictor_bht: RTL and testbench

//   Dynamic branch predictor shared by the IF and ID stages. At fetch it reads a table of
//   2-bit saturating counters indexed by the fetch PC and gives a taken/not-taken prediction.
//   It carries that prediction through its own F->D register. In ID it compares the prediction

---
 rtl/branch_predictor_bht.sv | 101 ++++++++++
 tb/tb_branch_predictor_bht.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_bht.sv
// Bimodal branch predictor: a table of 2-bit saturating counters read at fetch,
// a private F->D pipeline register, mispredict detection and training in decode.
module branch_predictor_bht #(
    parameter int unsigned IDX_W = 6,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [31:0]      pc_F,
    input  logic             valid_F,
    output logic             pred_taken_F,
    input  logic             stall_D,
    input  logic             flush_D,
    input  logic [3:0]       br_type_D,
    input  logic             br_taken_D,
    output logic             pred_taken_D,
    output logic             mispredict_D,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int unsigned DEPTH     = 2 ** IDX_W;
    localparam logic [3:0]  BR_OTHER  = 4'd8;
    localparam logic [1:0]  CNT_RESET = 2'b01;
    localparam logic [1:0]  CNT_MAX   = 2'b11;
    localparam logic [1:0]  CNT_MIN   = 2'b00;

    logic [1:0]       table_q [DEPTH];
    logic             vld_q;
    logic             pred_q;
    logic [IDX_W-1:0] idx_q;
    logic [CNT_W-1:0] br_cnt_q;
    logic [CNT_W-1:0] mispred_cnt_q;

    logic [IDX_W-1:0] idx_F;
    logic             is_cond;
    logic             train_en;
    logic [1:0]       cnt_old;
    logic [1:0]       cnt_new;
    logic             unused_pc;

    assign idx_F        = pc_F[IDX_W+1:2];
    assign unused_pc    = ^{pc_F[31:IDX_W+2], pc_F[1:0]};
    assign pred_taken_F = table_q[idx_F][1];

    assign is_cond      = (br_type_D < BR_OTHER);
    assign mispredict_D = vld_q & is_cond & (pred_q != br_taken_D);
    assign train_en     = vld_q & is_cond & ~stall_D & ~flush_D;
    assign pred_taken_D = pred_q;
    assign br_cnt       = br_cnt_q;
    assign mispred_cnt  = mispred_cnt_q;

    // Saturating counter update for the entry owned by the branch in ID
    always_comb begin
        cnt_old = table_q[idx_q];
        cnt_new = cnt_old;
        if (br_taken_D) begin
            if (cnt_old != CNT_MAX) cnt_new = cnt_old + 2'd1;
        end else begin
            if (cnt_old != CNT_MIN) cnt_new = cnt_old - 2'd1;
        end
    end

    // Counter table; writes land after the edge, so a same-cycle read sees the old value
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                table_q[i] <= CNT_RESET;
            end
        end else if (train_en) begin
            table_q[idx_q] <= cnt_new;
        end
    end

    // F->D register; flush wins over stall
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_q  <= 1'b0;
            pred_q <= 1'b0;
            idx_q  <= '0;
        end else if (flush_D) begin
            vld_q  <= 1'b0;
        end else if (!stall_D) begin
            vld_q  <= valid_F;
            pred_q <= pred_taken_F;
            idx_q  <= idx_F;
        end
    end

    // Wrap-around statistics
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            br_cnt_q      <= '0;
            mispred_cnt_q <= '0;
        end else if (train_en) begin
            br_cnt_q      <= br_cnt_q + CNT_W'(1);
            mispred_cnt_q <= mispred_cnt_q + CNT_W'(mispredict_D);
        end
    end

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Directed bench for branch_predictor_bht with hand-computed expectations.
module tb_branch_predictor_bht;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] pc_F;
    logic        valid_F;
    logic        pred_taken_F;
    logic        stall_D;
    logic        flush_D;
    logic [3:0]  br_type_D;
    logic        br_taken_D;
    logic        pred_taken_D;
    logic        mispredict_D;
    logic [31:0] br_cnt;
    logic [31:0] mispred_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    branch_predictor_bht #(.IDX_W(6), .CNT_W(32)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .pc_F         (pc_F),
        .valid_F      (valid_F),
        .pred_taken_F (pred_taken_F),
        .stall_D      (stall_D),
        .flush_D      (flush_D),
        .br_type_D    (br_type_D),
        .br_taken_D   (br_taken_D),
        .pred_taken_D (pred_taken_D),
        .mispredict_D (mispredict_D),
        .br_cnt       (br_cnt),
        .mispred_cnt  (mispred_cnt)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cnts(input string tag, input logic [31:0] bc, input logic [31:0] mc);
        chk32({tag, "_br_cnt"}, br_cnt, bc);
        chk32({tag, "_mispred_cnt"}, mispred_cnt, mc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Fetch one branch, then let it resolve in ID with a bubble behind it
    task automatic issue(input string tag, input logic [31:0] pc, input logic [3:0] bt,
                         input logic tk, input logic exp_pf, input logic exp_mis);
        pc_F = pc; valid_F = 1'b1; br_type_D = 4'd8; br_taken_D = 1'b0;
        #1 chk1({tag, "_predF"}, pred_taken_F, exp_pf);
        tick();
        valid_F = 1'b0; br_type_D = bt; br_taken_D = tk;
        #1 chk1({tag, "_predD"}, pred_taken_D, exp_pf);
        chk1({tag, "_mis"}, mispredict_D, exp_mis);
        tick();
    endtask

    initial begin
        resetn = 1'b0; pc_F = 32'h0; valid_F = 1'b0; stall_D = 1'b0; flush_D = 1'b0;
        br_type_D = 4'd8; br_taken_D = 1'b0;
        tick();
        chk1("rst_predD", pred_taken_D, 1'b0);
        chk1("rst_mis", mispredict_D, 1'b0);
        cnts("rst", 32'd0, 32'd0);
        @(negedge clk) resetn = 1'b1;
        tick();

        // Entry 0: 01 -> 10 on a taken branch predicted not-taken
        issue("t1", 32'h1000, 4'd0, 1'b1, 1'b0, 1'b1);
        cnts("t1", 32'd1, 32'd1);

        // 10 -> 11 -> 11 -> 11, then not-taken drops to 10, then 01
        issue("t2a", 32'h1000, 4'd0, 1'b1, 1'b1, 1'b0);
        issue("t2b", 32'h1000, 4'd0, 1'b1, 1'b1, 1'b0);
        issue("t2c", 32'h1000, 4'd0, 1'b1, 1'b1, 1'b0);
        cnts("t2sat", 32'd4, 32'd1);
        issue("t2d", 32'h1000, 4'd0, 1'b0, 1'b1, 1'b1);
        issue("t2e", 32'h1000, 4'd0, 1'b0, 1'b1, 1'b1);
        cnts("t2", 32'd6, 32'd3);
        issue("t2f", 32'h1000, 4'd0, 1'b0, 1'b0, 1'b0);
        cnts("t2f", 32'd7, 32'd3);

        // Stalled mispredicted branch: flagged each cycle, trained once on release
        pc_F = 32'h1004; valid_F = 1'b1; br_type_D = 4'd8;
        #1 chk1("t3_predF", pred_taken_F, 1'b0);
        tick();
        valid_F = 1'b0; br_type_D = 4'd1; br_taken_D = 1'b1; stall_D = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk1("t3_mis_stall", mispredict_D, 1'b1);
            cnts("t3_stall", 32'd7, 32'd3);
            tick();
        end
        stall_D = 1'b0;
        #1 chk1("t3_mis_rel", mispredict_D, 1'b1);
        tick();
        cnts("t3_rel", 32'd8, 32'd4);
        chk1("t3_bubble_mis", mispredict_D, 1'b0);
        pc_F = 32'h1004; br_type_D = 4'd8;
        #1 chk1("t3_entry1", pred_taken_F, 1'b1);

        // Flush together with stall: branch squashed, nothing trained
        pc_F = 32'h1008; valid_F = 1'b1; br_type_D = 4'd8;
        tick();
        valid_F = 1'b0; br_type_D = 4'd2; br_taken_D = 1'b1; stall_D = 1'b1; flush_D = 1'b1;
        #1 chk1("t4_mis_pre", mispredict_D, 1'b1);
        tick();
        stall_D = 1'b0; flush_D = 1'b0;
        #1 chk1("t4_mis_post", mispredict_D, 1'b0);
        cnts("t4", 32'd8, 32'd4);
        tick();
        cnts("t4b", 32'd8, 32'd4);
        pc_F = 32'h1008; br_type_D = 4'd8;
        #1 chk1("t4_entry2", pred_taken_F, 1'b0);

        // Same-cycle train/read of idx 5 via an aliasing PC; type 8 never trains
        pc_F = 32'h1014; valid_F = 1'b1; br_type_D = 4'd8;
        tick();
        pc_F = 32'h2014; valid_F = 1'b1; br_type_D = 4'd5; br_taken_D = 1'b1;
        #1 chk1("t5_old", pred_taken_F, 1'b0);
        chk1("t5_mis", mispredict_D, 1'b1);
        tick();
        valid_F = 1'b0; br_type_D = 4'd8; br_taken_D = 1'b1;
        #1 chk1("t5_new", pred_taken_F, 1'b1);
        chk1("t5_predD", pred_taken_D, 1'b0);
        chk1("t5_other_mis", mispredict_D, 1'b0);
        cnts("t5", 32'd9, 32'd5);
        tick();
        cnts("t5_other", 32'd9, 32'd5);
        issue("t5_t15", 32'h1018, 4'd15, 1'b1, 1'b0, 1'b0);
        cnts("t5_t15", 32'd9, 32'd5);

        // br_cnt wraps from all-ones to zero
        pc_F = 32'h1018; valid_F = 1'b1; br_type_D = 4'd8;
        tick();
        valid_F = 1'b0; br_type_D = 4'd0; br_taken_D = 1'b0;
        force dut.br_cnt_q = 32'hFFFF_FFFF;
        #1 release dut.br_cnt_q;
        #1 chk32("t6_preload", br_cnt, 32'hFFFF_FFFF);
        tick();
        cnts("t6_wrap", 32'd0, 32'd5);

        // Reset asserted while a mispredicted branch is stalled in ID
        pc_F = 32'h101C; valid_F = 1'b1; br_type_D = 4'd8;
        tick();
        valid_F = 1'b0; br_type_D = 4'd0; br_taken_D = 1'b1; stall_D = 1'b1;
        tick();
        #1 chk1("t6_mis_stall", mispredict_D, 1'b1);
        resetn = 1'b0;
        pc_F = 32'h1014;
        #1 chk1("t6_rst_mis", mispredict_D, 1'b0);
        chk1("t6_rst_predD", pred_taken_D, 1'b0);
        chk1("t6_rst_entry5", pred_taken_F, 1'b0);
        cnts("t6_rst", 32'd0, 32'd0);
        @(negedge clk) resetn = 1'b1;
        stall_D = 1'b0;
        tick();
        cnts("t6_after", 32'd0, 32'd0);
        pc_F = 32'h1000;
        #1 chk1("t6_entry0", pred_taken_F, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
